// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control unit for a multicycle RV32I core.
// A Moore FSM that steps a shared datapath (one ALU, one unified memory,
// IR/ALUOut/Data registers) through lw, sw, R-type, I-type ALU, beq and jal.
// It stalls on MemReady and, when MAX_WAIT is nonzero, enters FAULT after too
// many consecutive wait cycles. Unsupported encodings also enter FAULT, which
// is sticky until reset.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset (0 = reset)
//   op/funct3/funct7b5  instruction fields taken from IR
//   Zero        ALU zero flag
//   MemReady    memory completes the current access this cycle
//   AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl   datapath controls
//   InstrDone   one-cycle pulse in the last cycle of each instruction
//   Fault       high while in FAULT
//
// state     | meaning
// ----------+-----------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4 on MemReady
// DECODE    | compute branch/jump target into ALUOut
// MEMADR    | compute load/store address
// MEMREAD   | read data memory, wait for MemReady
// MEMWB     | write loaded data to register file
// MEMWR     | write data memory, wait for MemReady
// EXECR     | R-type ALU operation
// EXECI     | I-type ALU operation
// JAL       | PC <= target, ALUOut <= OldPC+4
// ALUWB     | write ALUOut to register file
// BEQ       | compare, PC <= target if equal
// FAULT     | unsupported encoding or wait timeout; sticky
module multicycle_ctrl #(
  parameter int MAX_WAIT = 0,
  parameter int WAITW    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       InstrDone,
  output logic       Fault
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BEQ, S_FAULT
  } state_t;

  state_t           state, state_nx;
  logic [WAITW-1:0] wait_cnt;
  logic             mem_state, timeout, f3_ok;
  logic             pc_update, branch, ir_wr, reg_wr, mem_wr, done;
  logic [1:0]       alu_op;

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWR);
  // Timeout fires on the wait cycle after MAX_WAIT waits have already elapsed.
  assign timeout   = (MAX_WAIT != 0) && mem_state && !MemReady &&
                     (wait_cnt == WAITW'(MAX_WAIT));
  assign f3_ok     = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:   if (MemReady) state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_R:         state_nx = f3_ok ? S_EXECR : S_FAULT;
          OP_I:         state_nx = f3_ok ? S_EXECI : S_FAULT;
          OP_JAL:       state_nx = S_JAL;
          OP_BEQ:       state_nx = S_BEQ;
          default:      state_nx = S_FAULT;
        endcase
      end
      S_MEMADR:  state_nx = op[5] ? S_MEMWR : S_MEMREAD;
      S_MEMREAD: if (MemReady) state_nx = S_MEMWB;
      S_MEMWB:   state_nx = S_FETCH;
      S_MEMWR:   if (MemReady) state_nx = S_FETCH;
      S_EXECR:   state_nx = S_ALUWB;
      S_EXECI:   state_nx = S_ALUWB;
      S_JAL:     state_nx = S_ALUWB;
      S_ALUWB:   state_nx = S_FETCH;
      S_BEQ:     state_nx = S_FETCH;
      S_FAULT:   state_nx = S_FAULT;
      default:   state_nx = S_FAULT;
    endcase
    if (timeout) state_nx = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      // Staying in a memory state means MemReady was low; any exit clears.
      if (mem_state && !MemReady && !timeout) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + WAITW'(1);
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_wr     = 1'b0;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    done      = 1'b0;
    Fault     = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_wr     = MemReady;
        pc_update = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_wr    = 1'b1;
        done      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
        done   = MemReady;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_ALUWB: begin
        reg_wr = 1'b1;
        done   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
        done    = 1'b1;
      end
      S_FAULT: Fault = 1'b1;
      default: Fault = 1'b1;
    endcase
  end

  // Write enables are gated by reset so nothing commits while it is held.
  assign IRWrite   = reset & ir_wr;
  assign PCWrite   = reset & (pc_update | (branch & Zero));
  assign RegWrite  = reset & reg_wr;
  assign MemWrite  = reset & mem_wr;
  assign InstrDone = reset & done;

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: instruction table, directed corner cases
// (memory waits, fault, timeout, reset mid-store) and a randomized
// instruction stream checked against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset2, MemReady, mr2, Zero, funct7b5;
  logic [6:0] op;
  logic [2:0] funct3;

  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, InstrDone, Fault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  logic       AdrSrc_2, IRWrite_2, PCWrite_2, RegWrite_2, MemWrite_2, InstrDone_2, Fault_2;
  logic [1:0] ResultSrc_2, ALUSrcA_2, ALUSrcB_2, ImmSrc_2;
  logic [2:0] ALUControl_2;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .InstrDone(InstrDone), .Fault(Fault)
  );

  multicycle_ctrl #(.MAX_WAIT(3), .WAITW(8)) dut2 (
    .clk(clk), .reset(reset2), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(mr2), .AdrSrc(AdrSrc_2), .IRWrite(IRWrite_2),
    .PCWrite(PCWrite_2), .RegWrite(RegWrite_2), .MemWrite(MemWrite_2),
    .ResultSrc(ResultSrc_2), .ALUSrcA(ALUSrcA_2), .ALUSrcB(ALUSrcB_2), .ImmSrc(ImmSrc_2),
    .ALUControl(ALUControl_2), .InstrDone(InstrDone_2), .Fault(Fault_2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       adr, irw, pcw, rw, mw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       done, fault;
  } outs_t;

  function automatic outs_t dut_outs();
    outs_t o;
    o.adr = AdrSrc; o.irw = IRWrite; o.pcw = PCWrite; o.rw = RegWrite; o.mw = MemWrite;
    o.rs = ResultSrc; o.sa = ALUSrcA; o.sb = ALUSrcB; o.imm = ImmSrc;
    o.alu = ALUControl; o.done = InstrDone; o.fault = Fault;
    return o;
  endfunction

  // ---------------- reference model ----------------
  typedef enum int {P_FETCH, P_DEC, P_ADR, P_RD, P_MWB, P_WR, P_EXR, P_EXI, P_JAL, P_AWB, P_BEQ} phase_t;
  phase_t plan[$];

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (f7 && is_r) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic outs_t model_out(input phase_t ph, input logic mr, input logic z,
                                      input logic [6:0] o, input logic [2:0] f3, input logic f7);
    outs_t e;
    e = '0;
    e.imm = imm_of(o);
    case (ph)
      P_FETCH: begin e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
      P_DEC:   begin e.sa = 2'b01; e.sb = 2'b01; end
      P_ADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      P_RD:    e.adr = 1'b1;
      P_MWB:   begin e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1; end
      P_WR:    begin e.adr = 1'b1; e.mw = 1'b1; e.done = mr; end
      P_EXR:   begin e.sa = 2'b10; e.alu = funct_alu(f3, f7, 1'b1); end
      P_EXI:   begin e.sa = 2'b10; e.sb = 2'b01; e.alu = funct_alu(f3, f7, 1'b0); end
      P_JAL:   begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      P_AWB:   begin e.rw = 1'b1; e.done = 1'b1; end
      P_BEQ:   begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; e.done = 1'b1; end
      default: e.fault = 1'b1;
    endcase
    return e;
  endfunction

  // ---------------- instruction table ----------------
  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         cycles;
    int         rw;
    int         mw;
    int         pcw;
    logic [1:0] imm;
    logic [2:0] alu3;
    logic [1:0] rs_last;
  } vec_t;

  vec_t tbl[12];

  task automatic run_vec(input vec_t v, input int idx);
    int done_at = 0;
    int nrw = 0, nmw = 0, npcw = 0;
    logic [2:0] alu3 = '0;
    logic [1:0] rs_last = '0, imm = '0;
    for (int c = 1; c <= 20 && done_at == 0; c++) begin
      @(negedge clk);
      op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z; MemReady = 1'b1;
      #1;
      nrw  += int'(RegWrite);
      nmw  += int'(MemWrite);
      npcw += int'(PCWrite);
      if (c == 1) imm = ImmSrc;
      if (c == 3) alu3 = ALUControl;
      if (InstrDone) begin done_at = c; rs_last = ResultSrc; end
    end
    chk($sformatf("v%0d cycles", idx), done_at, v.cycles);
    chk($sformatf("v%0d regwrite", idx), nrw, v.rw);
    chk($sformatf("v%0d memwrite", idx), nmw, v.mw);
    chk($sformatf("v%0d pcwrite", idx), npcw, v.pcw);
    chk($sformatf("v%0d immsrc", idx), imm, v.imm);
    chk($sformatf("v%0d alucontrol", idx), alu3, v.alu3);
    chk($sformatf("v%0d resultsrc_last", idx), rs_last, v.rs_last);
  endtask

  initial begin
    logic [0:5] pat;
    int nmw, ndone, done_at, nfault, nen;
    outs_t exp_o;

    tbl[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 1, 0, 1, 2'b00, 3'b000, 2'b01}; // lw
    tbl[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 0, 1, 1, 2'b01, 3'b000, 2'b00}; // sw
    tbl[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 1, 0, 1, 2'b00, 3'b000, 2'b00}; // add
    tbl[3]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 1, 0, 1, 2'b00, 3'b001, 2'b00}; // sub
    tbl[4]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 1, 0, 1, 2'b00, 3'b101, 2'b00}; // slt
    tbl[5]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 1, 0, 1, 2'b00, 3'b011, 2'b00}; // or
    tbl[6]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 1, 0, 1, 2'b00, 3'b010, 2'b00}; // and
    tbl[7]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 1, 0, 1, 2'b00, 3'b000, 2'b00}; // addi, f7=1
    tbl[8]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, 4, 1, 0, 1, 2'b00, 3'b101, 2'b00}; // slti
    tbl[9]  = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 1, 0, 2, 2'b11, 3'b000, 2'b00}; // jal
    tbl[10] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 0, 0, 2, 2'b10, 3'b001, 2'b00}; // beq taken
    tbl[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 0, 0, 1, 2'b10, 3'b001, 2'b00}; // beq not taken

    reset = 1'b0; reset2 = 1'b0; MemReady = 1'b1; mr2 = 1'b1; Zero = 1'b0;
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;

    // Reset state: enables forced low even with MemReady high in FETCH.
    @(negedge clk); @(negedge clk); #1;
    chk("rst irwrite", IRWrite, 1'b0);
    chk("rst pcwrite", PCWrite, 1'b0);
    chk("rst fault", Fault, 1'b0);
    chk("rst fetch_sel", {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 7'b0_00_10_10);
    @(negedge clk);
    reset = 1'b1; MemReady = 1'b0;
    #1;
    chk("fetch wait irwrite", IRWrite, 1'b0);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // sw with two wait cycles in MEMWR
    op = 7'b0100011; funct3 = 3'b010;
    pat = 6'b111001;
    nmw = 0; ndone = 0; done_at = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      MemReady = pat[c-1];
      #1;
      nmw += int'(MemWrite);
      if (InstrDone) begin ndone++; done_at = c; end
    end
    chk("sw_wait memwrite_cycles", nmw, 3);
    chk("sw_wait done_count", ndone, 1);
    chk("sw_wait done_cycle", done_at, 6);
    @(negedge clk); MemReady = 1'b0; #1;
    chk("sw_wait back_fetch", {AdrSrc, ALUSrcB, ResultSrc, MemWrite}, 6'b0_10_10_0);

    // Illegal opcode -> sticky FAULT
    op = 7'b1111111;
    @(negedge clk); MemReady = 1'b1;
    @(negedge clk);
    nfault = 0; nen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      nfault += int'(Fault);
      nen += int'(IRWrite | PCWrite | RegWrite | MemWrite | InstrDone);
    end
    chk("fault cycles", nfault, 10);
    chk("fault enables", nen, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; MemReady = 1'b0; #1;
    chk("fault cleared", Fault, 1'b0);
    chk("fault fetch_sel", {AdrSrc, ALUSrcB}, 3'b0_10);

    // Reset during MEMWR
    op = 7'b0100011;
    @(negedge clk); MemReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); MemReady = 1'b0; #1;
    chk("rst_memwr before", MemWrite, 1'b1);
    reset = 1'b0; #1;
    chk("rst_memwr forced", {MemWrite, InstrDone}, 2'b00);
    @(negedge clk); reset = 1'b1; MemReady = 1'b0; #1;
    chk("rst_memwr fetch", {AdrSrc, ALUSrcB, MemWrite}, 4'b0_10_0);

    // Wait timeout on dut2 (MAX_WAIT=3)
    reset2 = 1'b1; mr2 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk); #1;
      chk($sformatf("timeout edge%0d", e), Fault_2, (e == 4));
    end
    chk("timeout memwrite", MemWrite_2, 1'b0);
    // Exactly MAX_WAIT waits is still tolerated
    @(negedge clk); reset2 = 1'b0;
    @(negedge clk); reset2 = 1'b1; mr2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mr2 = 1'b1; #1;
    chk("maxwait irwrite", {IRWrite_2, Fault_2}, 2'b10);
    @(negedge clk); #1;
    chk("maxwait decode", {ALUSrcA_2, Fault_2}, 3'b01_0);
    reset2 = 1'b0;

    // Randomized instruction stream against the reference model
    plan.delete();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (plan.size() == 0) begin
        int cls;
        logic [2:0] f3s;
        cls = $urandom_range(0, 5);
        f3s = 3'($urandom_range(0, 3));
        funct7b5 = 1'($urandom_range(0, 1));
        funct3 = (f3s == 3'd0) ? 3'b000 : (f3s == 3'd1) ? 3'b010 : (f3s == 3'd2) ? 3'b110 : 3'b111;
        plan.push_back(P_FETCH);
        plan.push_back(P_DEC);
        case (cls)
          0: begin op = 7'b0000011; plan.push_back(P_ADR); plan.push_back(P_RD); plan.push_back(P_MWB); end
          1: begin op = 7'b0100011; plan.push_back(P_ADR); plan.push_back(P_WR); end
          2: begin op = 7'b0110011; plan.push_back(P_EXR); plan.push_back(P_AWB); end
          3: begin op = 7'b0010011; plan.push_back(P_EXI); plan.push_back(P_AWB); end
          4: begin op = 7'b1101111; plan.push_back(P_JAL); plan.push_back(P_AWB); end
          default: begin op = 7'b1100011; plan.push_back(P_BEQ); end
        endcase
      end
      MemReady = ($urandom_range(0, 3) != 0);
      Zero = 1'($urandom_range(0, 1));
      #1;
      exp_o = model_out(plan[0], MemReady, Zero, op, funct3, funct7b5);
      chk($sformatf("rand%0d", i), dut_outs(), exp_o);
      if (!((plan[0] == P_FETCH || plan[0] == P_RD || plan[0] == P_WR) && !MemReady))
        void'(plan.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
